// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    SETTLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  localparam int LOSS_W = 8;

  // One counter covers every state, so size it for the longest interval.
  // The extra bit leaves headroom so the terminal value never wraps.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_bit.sv
// N-stage single-bit synchroniser with asynchronous active-low clear.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: arms an external PLL, qualifies its LOCK output and
// releases the downstream reset once lock has been stable long enough.
// Optional macro PLL_LOSS_COUNT_EN adds loss_count / lock_lost outputs.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int SETTLE_CYCLES  = 1024,
  parameter int SYNC_STAGES    = 2,
  parameter int RETRY_W        = 4
) (
  input  logic               clock_in,
  input  logic               reset_n,
  input  logic               pll_lock,
  output logic               pll_resetb,
  output logic               rst_req_n,
  output logic               locked,
  output logic [RETRY_W-1:0] retries
`ifdef PLL_LOSS_COUNT_EN
  ,
  output logic [LOSS_W-1:0]  loss_count,
  output logic               lock_lost
`endif
);

  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);

  pll_state_e    state;
  logic [CW-1:0] cnt;
  logic          lock_s;
  logic          sync_clr_n;

  // LOCK is meaningless while the PLL is held in reset, so the synchroniser
  // is kept cleared until pll_resetb rises; qualification then always starts
  // from a clean chain on WAIT_LOCK entry.
  assign sync_clr_n = reset_n & pll_resetb;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clock_in),
    .clr_n (sync_clr_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // Sequencer FSM; outputs only change on transitions so they are set there.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state      <= PLL_RST;
      cnt        <= '0;
      pll_resetb <= 1'b0;
      rst_req_n  <= 1'b0;
      locked     <= 1'b0;
      retries    <= '0;
`ifdef PLL_LOSS_COUNT_EN
      loss_count <= '0;
      lock_lost  <= 1'b0;
`endif
    end else begin
      case (state)
        PLL_RST: begin
          if (cnt == RST_LAST) begin
            state      <= WAIT_LOCK;
            cnt        <= '0;
            pll_resetb <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          // Lock takes priority over a coincident timeout.
          if (lock_s) begin
            state <= SETTLE;
            cnt   <= '0;
          end else if (cnt == TO_LAST) begin
            state      <= PLL_RST;
            cnt        <= '0;
            pll_resetb <= 1'b0;
            if (retries != '1) retries <= retries + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SETTLE: begin
          // Any dropout forfeits all settle progress.
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == SET_LAST) begin
            state     <= RUN;
            cnt       <= '0;
            rst_req_n <= 1'b1;
            locked    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          // Lock loss drops the downstream reset but leaves the PLL running;
          // only a subsequent timeout re-arms it.
          if (!lock_s) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            rst_req_n <= 1'b0;
            locked    <= 1'b0;
`ifdef PLL_LOSS_COUNT_EN
            if (loss_count != '1) loss_count <= loss_count + 1'b1;
            lock_lost <= 1'b1;
`endif
          end
        end
        default: begin
          state      <= PLL_RST;
          cnt        <= '0;
          pll_resetb <= 1'b0;
          rst_req_n  <= 1'b0;
          locked     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed self-checking bench for pll_lock_sequencer.
// Edge numbers count rising clock edges after reset_n release (first = 1).
module tb_pll_lock_sequencer;

  logic       clock_in;
  logic       reset_n;
  logic       pll_lock;
  logic       pll_resetb;
  logic       rst_req_n;
  logic       locked;
  logic [3:0] retries;
`ifdef PLL_LOSS_COUNT_EN
  logic [7:0] loss_count;
  logic       lock_lost;
`endif

  int cyc;
  int passed;
  int total;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES (16),
    .LOCK_TIMEOUT   (32),
    .SETTLE_CYCLES  (8),
    .SYNC_STAGES    (2),
    .RETRY_W        (4)
  ) dut (
    .clock_in   (clock_in),
    .reset_n    (reset_n),
    .pll_lock   (pll_lock),
    .pll_resetb (pll_resetb),
    .rst_req_n  (rst_req_n),
    .locked     (locked),
    .retries    (retries)
`ifdef PLL_LOSS_COUNT_EN
    ,
    .loss_count (loss_count),
    .lock_lost  (lock_lost)
`endif
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock_in);
    cyc++;
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic apply_reset(input logic lock);
    reset_n  = 1'b0;
    pll_lock = lock;
    tick();
    tick();
    @(negedge clock_in);
    reset_n = 1'b1;
    cyc     = 0;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    pll_lock = 1'b0;
    tick();
    tick();
    total++; if (pll_resetb !== 1'b0) $display("FAIL reset_pll_resetb: got %b want 0", pll_resetb); else passed++;
    total++; if (rst_req_n !== 1'b0) $display("FAIL reset_rst_req_n: got %b want 0", rst_req_n); else passed++;
    total++; if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked); else passed++;
    total++; if (retries !== 4'd0) $display("FAIL reset_retries: got %0d want 0", retries); else passed++;
`ifdef PLL_LOSS_COUNT_EN
    total++; if (loss_count !== 8'd0) $display("FAIL reset_loss_count: got %0d want 0", loss_count); else passed++;
    total++; if (lock_lost !== 1'b0) $display("FAIL reset_lock_lost: got %b want 0", lock_lost); else passed++;
`endif
  endtask

  // Lock high throughout: WAIT_LOCK at edge 16, RUN at edge 27.
  task automatic test_lock_held();
    apply_reset(1'b1);
    wait_until(15);
    total++; if (pll_resetb !== 1'b0) $display("FAIL held_resetb_e15: got %b want 0", pll_resetb); else passed++;
    wait_until(16);
    total++; if (pll_resetb !== 1'b1) $display("FAIL held_resetb_e16: got %b want 1", pll_resetb); else passed++;
    total++; if (locked !== 1'b0) $display("FAIL held_locked_e16: got %b want 0", locked); else passed++;
    wait_until(26);
    total++; if (rst_req_n !== 1'b0) $display("FAIL held_rstreq_e26: got %b want 0", rst_req_n); else passed++;
    wait_until(27);
    total++; if (rst_req_n !== 1'b1) $display("FAIL held_rstreq_e27: got %b want 1", rst_req_n); else passed++;
    total++; if (locked !== 1'b1) $display("FAIL held_locked_e27: got %b want 1", locked); else passed++;
    total++; if (retries !== 4'd0) $display("FAIL held_retries: got %0d want 0", retries); else passed++;
  endtask

  // Continues from RUN at edge 27; lock dropped after edge 27.
  task automatic test_run_loss();
    pll_lock = 1'b0;
    wait_until(29);
    total++; if (rst_req_n !== 1'b1) $display("FAIL loss_rstreq_e29: got %b want 1", rst_req_n); else passed++;
    wait_until(30);
    total++; if (rst_req_n !== 1'b0) $display("FAIL loss_rstreq_e30: got %b want 0", rst_req_n); else passed++;
    total++; if (locked !== 1'b0) $display("FAIL loss_locked_e30: got %b want 0", locked); else passed++;
    total++; if (pll_resetb !== 1'b1) $display("FAIL loss_resetb_e30: got %b want 1", pll_resetb); else passed++;
`ifdef PLL_LOSS_COUNT_EN
    total++; if (loss_count !== 8'd1) $display("FAIL loss_count: got %0d want 1", loss_count); else passed++;
    total++; if (lock_lost !== 1'b1) $display("FAIL loss_lock_lost: got %b want 1", lock_lost); else passed++;
`endif
    wait_until(61);
    total++; if (pll_resetb !== 1'b1) $display("FAIL loss_no_rearm_e61: got %b want 1", pll_resetb); else passed++;
  endtask

  // Lock rises after edge 16; lock_s low during settle count 5 -> RUN at 34.
  task automatic test_settle_glitch();
    apply_reset(1'b0);
    wait_until(16);
    pll_lock = 1'b1;
    wait_until(22);
    pll_lock = 1'b0;
    wait_until(23);
    pll_lock = 1'b1;
    wait_until(27);
    total++; if (rst_req_n !== 1'b0) $display("FAIL glitch_rstreq_e27: got %b want 0", rst_req_n); else passed++;
    wait_until(33);
    total++; if (rst_req_n !== 1'b0) $display("FAIL glitch_rstreq_e33: got %b want 0", rst_req_n); else passed++;
    wait_until(34);
    total++; if (rst_req_n !== 1'b1) $display("FAIL glitch_rstreq_e34: got %b want 1", rst_req_n); else passed++;
    total++; if (locked !== 1'b1) $display("FAIL glitch_locked_e34: got %b want 1", locked); else passed++;
  endtask

  // lock_s first reads 1 while cnt = 31 (cycle after edge 47).
  task automatic test_timeout_coincide();
    apply_reset(1'b0);
    wait_until(45);
    pll_lock = 1'b1;
    wait_until(48);
    total++; if (pll_resetb !== 1'b1) $display("FAIL coinc_resetb_e48: got %b want 1", pll_resetb); else passed++;
    total++; if (retries !== 4'd0) $display("FAIL coinc_retries_e48: got %0d want 0", retries); else passed++;
    wait_until(55);
    total++; if (rst_req_n !== 1'b0) $display("FAIL coinc_rstreq_e55: got %b want 0", rst_req_n); else passed++;
    wait_until(56);
    total++; if (rst_req_n !== 1'b1) $display("FAIL coinc_rstreq_e56: got %b want 1", rst_req_n); else passed++;
  endtask

  // No lock: 48-cycle re-arm period, 16 cycles low, retries saturate at 15.
  task automatic test_timeout();
    int exp_r;
    apply_reset(1'b0);
    wait_until(47);
    total++; if (pll_resetb !== 1'b1) $display("FAIL to_resetb_e47: got %b want 1", pll_resetb); else passed++;
    total++; if (retries !== 4'd0) $display("FAIL to_retries_e47: got %0d want 0", retries); else passed++;
    wait_until(48);
    total++; if (pll_resetb !== 1'b0) $display("FAIL to_resetb_e48: got %b want 0", pll_resetb); else passed++;
    total++; if (retries !== 4'd1) $display("FAIL to_retries_e48: got %0d want 1", retries); else passed++;
    wait_until(63);
    total++; if (pll_resetb !== 1'b0) $display("FAIL to_resetb_e63: got %b want 0", pll_resetb); else passed++;
    wait_until(64);
    total++; if (pll_resetb !== 1'b1) $display("FAIL to_resetb_e64: got %b want 1", pll_resetb); else passed++;
    for (int k = 2; k <= 17; k++) begin
      exp_r = (k > 15) ? 15 : k;
      wait_until(48 * k);
      total++; if (retries !== 4'(exp_r)) $display("FAIL to_retries_k%0d: got %0d want %0d", k, retries, exp_r); else passed++;
      total++; if (pll_resetb !== 1'b0) $display("FAIL to_pulse_k%0d: got %b want 0", k, pll_resetb); else passed++;
    end
  endtask

  // Continues at edge 816 (PLL_RST entry, retries 15); lock then RUN at 843.
  task automatic test_async_reset_run();
    pll_lock = 1'b1;
    wait_until(843);
    total++; if (locked !== 1'b1) $display("FAIL arun_locked_e843: got %b want 1", locked); else passed++;
    total++; if (retries !== 4'd15) $display("FAIL arun_retries_e843: got %0d want 15", retries); else passed++;
    #2 reset_n = 1'b0;
    #1;
    total++; if (pll_resetb !== 1'b0) $display("FAIL arun_resetb_async: got %b want 0", pll_resetb); else passed++;
    total++; if (rst_req_n !== 1'b0) $display("FAIL arun_rstreq_async: got %b want 0", rst_req_n); else passed++;
    total++; if (locked !== 1'b0) $display("FAIL arun_locked_async: got %b want 0", locked); else passed++;
    total++; if (retries !== 4'd0) $display("FAIL arun_retries_async: got %0d want 0", retries); else passed++;
    apply_reset(1'b1);
    wait_until(15);
    total++; if (pll_resetb !== 1'b0) $display("FAIL arun_restart_e15: got %b want 0", pll_resetb); else passed++;
    wait_until(16);
    total++; if (pll_resetb !== 1'b1) $display("FAIL arun_restart_e16: got %b want 1", pll_resetb); else passed++;
    wait_until(27);
    total++; if (rst_req_n !== 1'b1) $display("FAIL arun_restart_e27: got %b want 1", rst_req_n); else passed++;
  endtask

  // Reset asserted while in SETTLE (edge 20 = settle count 1).
  task automatic test_async_reset_settle();
    apply_reset(1'b1);
    wait_until(20);
    total++; if (pll_resetb !== 1'b1) $display("FAIL aset_resetb_e20: got %b want 1", pll_resetb); else passed++;
    total++; if (rst_req_n !== 1'b0) $display("FAIL aset_rstreq_e20: got %b want 0", rst_req_n); else passed++;
    #2 reset_n = 1'b0;
    #1;
    total++; if (pll_resetb !== 1'b0) $display("FAIL aset_resetb_async: got %b want 0", pll_resetb); else passed++;
    total++; if (locked !== 1'b0) $display("FAIL aset_locked_async: got %b want 0", locked); else passed++;
    apply_reset(1'b1);
    wait_until(15);
    total++; if (pll_resetb !== 1'b0) $display("FAIL aset_restart_e15: got %b want 0", pll_resetb); else passed++;
    wait_until(16);
    total++; if (pll_resetb !== 1'b1) $display("FAIL aset_restart_e16: got %b want 1", pll_resetb); else passed++;
    wait_until(26);
    total++; if (rst_req_n !== 1'b0) $display("FAIL aset_restart_e26: got %b want 0", rst_req_n); else passed++;
    wait_until(27);
    total++; if (rst_req_n !== 1'b1) $display("FAIL aset_restart_e27: got %b want 1", rst_req_n); else passed++;
  endtask

  initial begin
    passed   = 0;
    total    = 0;
    cyc      = 0;
    reset_n  = 1'b0;
    pll_lock = 1'b0;
    test_reset();
    test_lock_held();
    test_run_loss();
    test_settle_glitch();
    test_timeout_coincide();
    test_timeout();
    test_async_reset_run();
    test_async_reset_settle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
